// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types and helpers for the iterative AES-128 core.
//   aes_ctrl_state_t : round controller states
//   AES_NR           : AES-128 round count
//   RCON_INIT        : first round constant
//   xtime()          : multiply by x in GF(2^8); used by rcon and MixColumns
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } aes_ctrl_state_t;

    localparam int         AES_NR    = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    // Multiply by {02} modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl_if
// Handshake and control-strobe bundle between the AES round controller and
// its host (start/done) plus datapath (selects and enables).
//   master : host / datapath side - drives start, observes everything else
//   slave  : controller side      - receives start, drives status and strobes
// ---------------------------------------------------------------------------
interface aes_round_ctrl_if #(
    parameter int RW = 4
);
    logic          start;
    logic          busy;
    logic          done;
    logic [RW-1:0] round;
    logic [7:0]    rcon;
    logic          init_sel;
    logic          state_en;
    logic          key_en;
    logic          mix_en;

    modport master (
        output start,
        input  busy, done, round, rcon, init_sel, state_en, key_en, mix_en
    );

    modport slave (
        input  start,
        output busy, done, round, rcon, init_sel, state_en, key_en, mix_en
    );
endinterface

// File: rtl/aes_rcon_gen.sv
// ---------------------------------------------------------------------------
// aes_rcon_gen
// Round-constant register for AES key expansion.
//   clk     : system clock
//   reset   : synchronous, active-high
//   clear   : load RCON_INIT (asserted during the initial key addition)
//   advance : step to xtime(rcon) (asserted on every keyed round)
//   rcon    : current raw constant (ungated; caller masks outside rounds)
// ---------------------------------------------------------------------------
module aes_rcon_gen
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       advance,
    output logic [7:0] rcon
);

    logic [7:0] rcon_q;

    // clear has priority so a restart always begins at 01 regardless of
    // where the previous sequence stopped.
    always_ff @(posedge clk) begin
        if (reset)        rcon_q <= 8'h00;
        else if (clear)   rcon_q <= RCON_INIT;
        else if (advance) rcon_q <= xtime(rcon_q);
    end

    assign rcon = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
// Sequencing controller for the iterative AES-128 encryption datapath.
// Walks INIT -> ROUND x (NR-1) -> FINAL -> DONE and emits Moore-decoded
// control strobes; no 128-bit state lives here.
//   clk, reset     : clock, synchronous active-high reset
//   ctl.start      : begin an encryption (ignored while busy)
//   ctl.busy       : high in INIT, ROUND and FINAL
//   ctl.done       : ciphertext valid, held until next accepted start/reset
//   ctl.round      : 0 in INIT, 1..NR in ROUND/FINAL, 0 otherwise
//   ctl.rcon       : key-expansion constant, 00 outside ROUND/FINAL
//   ctl.init_sel   : 1 = plaintext/cipher key into state/key registers
//   ctl.state_en   : state register load enable
//   ctl.key_en     : round-key register load enable
//   ctl.mix_en     : 1 = MixColumns included, 0 = bypass (final round)
// NR must be in 2..10 and representable in RW bits.
// ---------------------------------------------------------------------------
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int RW = 4
) (
    input  logic             clk,
    input  logic             reset,
    aes_round_ctrl_if.slave  ctl
);

    aes_ctrl_state_t state_q, state_d;
    logic [RW-1:0]   round_q;
    logic [7:0]      rcon_raw;
    logic            in_rnd;

    logic            busy_o, done_o, init_sel_o, state_en_o, key_en_o, mix_en_o;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ctl.start) state_d = INIT;
            INIT:    state_d = ROUND;
            ROUND:   if (round_q == RW'(NR - 1)) state_d = FINAL;
            FINAL:   state_d = DONE;
            DONE:    if (ctl.start) state_d = INIT;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Round counter: primed to 1 while in INIT so it reads 1 in the first
    // ROUND cycle, and cleared in every non-round state so it can never
    // carry a stale value past FINAL.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            round_q <= '0;
        end else begin
            case (state_q)
                INIT:    round_q <= RW'(1);
                ROUND:   round_q <= round_q + RW'(1);
                default: round_q <= '0;
            endcase
        end
    end

    assign in_rnd = (state_q == ROUND) || (state_q == FINAL);

    // Register is loaded with 01 during INIT and steps once per keyed round,
    // so round r sees the r-th constant.
    aes_rcon_gen u_rcon (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == INIT),
        .advance (in_rnd),
        .rcon    (rcon_raw)
    );

    // ------------------------------------------------------------------
    // Output decode (state only; start never reaches an output directly)
    // ------------------------------------------------------------------
    always_comb begin
        busy_o     = 1'b0;
        done_o     = 1'b0;
        init_sel_o = 1'b0;
        state_en_o = 1'b0;
        key_en_o   = 1'b0;
        mix_en_o   = 1'b0;
        case (state_q)
            INIT: begin
                busy_o     = 1'b1;
                init_sel_o = 1'b1;
                state_en_o = 1'b1;
                key_en_o   = 1'b1;
            end
            ROUND: begin
                busy_o     = 1'b1;
                state_en_o = 1'b1;
                key_en_o   = 1'b1;
                mix_en_o   = 1'b1;
            end
            FINAL: begin
                busy_o     = 1'b1;
                state_en_o = 1'b1;
                key_en_o   = 1'b1;
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    assign ctl.busy     = busy_o;
    assign ctl.done     = done_o;
    assign ctl.round    = round_q;
    assign ctl.rcon     = in_rnd ? rcon_raw : 8'h00;
    assign ctl.init_sel = init_sel_o;
    assign ctl.state_en = state_en_o;
    assign ctl.key_en   = key_en_o;
    assign ctl.mix_en   = mix_en_o;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl
// Directed bench for aes_round_ctrl. Each driven step pushes the expected
// per-cycle control vector into a scoreboard queue; every cycle one entry is
// popped and compared. A behavioural AES datapath driven by the controller's
// strobes checks the FIPS-197 Appendix B vector end to end.
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam int RW = 4;

    localparam logic [127:0] KEY   = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] PT    = 128'h3243F6A8885A308D313198A2E0370734;
    localparam logic [127:0] S_INI = 128'h193DE3BEA0F4E22B9AC68D2AE9F84808;
    localparam logic [127:0] CT    = 128'h3925841D02DC09FBDC118597196A0B32;

    logic clk;
    logic reset;

    aes_round_ctrl_if #(.RW(RW)) c ();

    aes_round_ctrl #(.NR(NR), .RW(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- GF(2^8) / AES reference helpers ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from first principles: multiplicative inverse (x^254) + affine.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r, p, e;
        r = 8'h01;
        p = x;
        e = 8'hFE;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] getb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int cc = 0; cc < 4; cc++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*cc+r) -: 8] = sbox(getb(s, 4*((cc+r)%4)+r));
        return o;
    endfunction

    function automatic logic [127:0] mixcol(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int cc = 0; cc < 4; cc++) begin
            a0 = getb(s, 4*cc);   a1 = getb(s, 4*cc+1);
            a2 = getb(s, 4*cc+2); a3 = getb(s, 4*cc+3);
            o[127-8*(4*cc)   -: 8] = gmul(a0,2) ^ gmul(a1,3) ^ a2 ^ a3;
            o[127-8*(4*cc+1) -: 8] = a0 ^ gmul(a1,2) ^ gmul(a2,3) ^ a3;
            o[127-8*(4*cc+2) -: 8] = a0 ^ a1 ^ gmul(a2,2) ^ gmul(a3,3);
            o[127-8*(4*cc+3) -: 8] = gmul(a0,3) ^ a1 ^ a2 ^ gmul(a3,2);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rc, 24'h0};
        w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] rnd(input logic [127:0] s, input logic [127:0] k,
                                         input logic [7:0] rc, input logic mix);
        logic [127:0] ss;
        ss = sub_shift(s);
        if (mix) ss = mixcol(ss);
        return ss ^ key_exp(k, rc);
    endfunction

    // Datapath obeying the controller's strobes.
    logic [127:0] dp_state, dp_key;
    always @(posedge clk) begin
        if (c.state_en) begin
            if (c.init_sel) begin
                dp_state <= PT ^ KEY;
                dp_key   <= KEY;
            end else begin
                dp_state <= rnd(dp_state, dp_key, c.rcon, c.mix_en);
                dp_key   <= key_exp(dp_key, c.rcon);
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        string       tag;
        logic [17:0] v;
    } exp_t;

    exp_t  sb[$];
    string phase;
    int    n_chk  = 0;
    int    n_fail = 0;

    function automatic logic [7:0] rc_exp(input int r);
        case (r)
            1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
            5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
            9: return 8'h1B; 10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // {busy, done, round, rcon, init_sel, state_en, key_en, mix_en}
    function automatic logic [17:0] mk(input logic b, input logic d, input int r,
                                       input logic [7:0] rc, input logic is,
                                       input logic se, input logic ke, input logic me);
        logic [RW-1:0] rr;
        rr = RW'(r);
        return {b, d, rr, rc, is, se, ke, me};
    endfunction

    function automatic logic [17:0] obs();
        return {c.busy, c.done, c.round, c.rcon, c.init_sel, c.state_en, c.key_en, c.mix_en};
    endfunction

    task automatic push(input string t, input logic [17:0] v);
        exp_t e;
        e.tag = {phase, "/", t};
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push("idle", mk(0,0,0,8'h00,0,0,0,0));
    endtask

    task automatic push_done(input int n);
        for (int i = 0; i < n; i++) push("done", mk(0,1,0,8'h00,0,0,0,0));
    endtask

    // First n cycles of an encryption: INIT, ROUND 1..NR-1, FINAL.
    task automatic push_enc(input int n);
        for (int k = 0; k < n; k++) begin
            if (k == 0)
                push("init", mk(1,0,0,8'h00,1,1,1,0));
            else if (k < NR)
                push($sformatf("round%0d", k), mk(1,0,k,rc_exp(k),0,1,1,1));
            else
                push("final", mk(1,0,NR,rc_exp(NR),0,1,1,0));
        end
    endtask

    task automatic cyc();
        exp_t       e;
        logic [17:0] o;
        @(posedge clk);
        #1;
        n_chk++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL %s/sb_empty: observed %h with no expected entry", phase, obs());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            o = obs();
            n_chk++;
            assert (o === e.v) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, o, e.v);
            end
        end
    endtask

    task automatic chk128(input string t, input logic [127:0] o, input logic [127:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %h expected %h", phase, t, o, e);
        end
    endtask

    // One complete encryption from IDLE/DONE with datapath checks.
    task automatic run_full();
        c.start = 1'b1;
        push_enc(NR + 1);
        cyc();                       // INIT
        c.start = 1'b0;
        cyc();                       // round 1; INIT load has landed
        chk128("state_after_init", dp_state, S_INI);
        repeat (NR - 1) cyc();       // rounds 2..NR
        push_done(2);
        cyc();
        chk128("ciphertext", dp_state, CT);
        cyc();
    endtask

    initial begin
        reset   = 1'b1;
        c.start = 1'b0;

        phase = "reset";
        push_idle(2);
        cyc(); cyc();
        reset = 1'b0;
        push_idle(1);
        cyc();

        // Basic sequence, rcon log and datapath vector.
        phase = "basic";
        run_full();

        // start pulsed mid-run is ignored; restart from DONE.
        phase = "midstart";
        c.start = 1'b1;
        push_enc(NR + 1);
        cyc();
        c.start = 1'b0;
        repeat (5) cyc();            // rounds 1..5
        c.start = 1'b1;
        cyc();                       // round 6
        c.start = 1'b0;
        repeat (NR - 6) cyc();       // rounds 7..NR
        push_done(2);
        cyc(); cyc();
        c.start = 1'b1;
        push_enc(NR + 1);
        cyc();                       // INIT, done already low
        c.start = 1'b0;
        repeat (NR) cyc();
        push_done(1);
        cyc();

        // Reset during round 6 aborts; fresh run afterwards.
        phase = "abort";
        c.start = 1'b1;
        push_enc(7);
        cyc();
        c.start = 1'b0;
        repeat (6) cyc();            // rounds 1..6
        reset = 1'b1;
        push_idle(1);
        cyc();
        reset = 1'b0;
        push_idle(1);
        cyc();
        phase = "after_abort";
        run_full();

        // start held: back-to-back encryptions every NR+2 cycles.
        phase = "held";
        c.start = 1'b1;
        for (int n = 0; n < 3; n++) begin
            push_enc(NR + 1);
            push_done(1);
            repeat (NR + 2) cyc();
        end
        chk128("held_ciphertext", dp_state, CT);
        c.start = 1'b0;
        push_done(2);
        cyc(); cyc();

        phase = "end";
        n_chk++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL end/sb_leftover: observed %0d entries expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
